// File: rtl/dcache_arb_pkg.sv
// Shared types and widths for the data-cache port arbiter.
//   DC_ADDR_W   : word address width of the data RAM
//   DC_DATA_W   : data word width
//   DC_BE_W     : byte-enable width
//   ret_owner_e : which requester owns the read data returning next cycle
package dcache_arb_pkg;

    localparam int unsigned DC_ADDR_W = 12;
    localparam int unsigned DC_DATA_W = 32;
    localparam int unsigned DC_BE_W   = 4;

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_PIPE = 2'd1,
        RET_AUX  = 2'd2
    } ret_owner_e;

endpackage

// File: rtl/dcache_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data RAM.
// The memory stage (pipe) has fixed priority over the auxiliary loader/debug
// port (aux). Grants are combinational; read data comes back from the RAM one
// cycle after the grant and is tagged to its requester by a registered
// return-owner state. Denied requests are not buffered: requesters hold.
//
// Configuration macro: DCACHE_ARB_STARVE_GUARD_EN
//   defined   : aux is forced a grant after STARVE_MAX consecutive denied cycles
//   undefined : strict pipe-first priority, pipe_gnt == pipe_req
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   pipe_*/aux_* req,we,addr,    request, write strobe, word address,
//     wdata,be                   write data, byte enables
//   pipe_gnt/aux_gnt             access accepted this cycle
//   pipe_rvalid/aux_rvalid       rdata belongs to that requester this cycle
//   rdata                        read data (straight from ram_q)
//   ram_addr/data/byteena/wren   RAM command outputs
//   ram_q                        RAM read data, 1-cycle latency
module dcache_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_req,
    input  logic                 aux_req,
    input  logic                 pipe_we,
    input  logic                 aux_we,
    input  logic [DC_ADDR_W-1:0] pipe_addr,
    input  logic [DC_ADDR_W-1:0] aux_addr,
    input  logic [DC_DATA_W-1:0] pipe_wdata,
    input  logic [DC_DATA_W-1:0] aux_wdata,
    input  logic [DC_BE_W-1:0]   pipe_be,
    input  logic [DC_BE_W-1:0]   aux_be,
    output logic                 pipe_gnt,
    output logic                 aux_gnt,
    output logic                 pipe_rvalid,
    output logic                 aux_rvalid,
    output logic [DC_DATA_W-1:0] rdata,
    output logic [DC_ADDR_W-1:0] ram_addr,
    output logic [DC_DATA_W-1:0] ram_data,
    output logic [DC_BE_W-1:0]   ram_byteena,
    output logic                 ram_wren,
    input  logic [DC_DATA_W-1:0] ram_q
);

    ret_owner_e ret_q, ret_d;
    logic       aux_force;

`ifdef DCACHE_ARB_STARVE_GUARD_EN
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;

    assign aux_force = aux_req && (starve_q == StarveMax);

    // Counts consecutive denied aux cycles; any aux grant or idle aux clears it.
    always_comb begin
        starve_d = 4'd0;
        if (aux_req && !aux_gnt) begin
            starve_d = (starve_q == StarveMax) ? StarveMax : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic [3:0] unused_starve_max;

    assign unused_starve_max = 4'(STARVE_MAX);
    assign aux_force         = 1'b0;
`endif

    always_comb begin
        pipe_gnt = pipe_req & ~aux_force;
        // aux_force implies aux_req, so aux wins either when pipe is idle or forced.
        aux_gnt  = aux_req & ~pipe_gnt;

        ram_addr    = pipe_addr;
        ram_data    = pipe_wdata;
        ram_byteena = '0;
        ram_wren    = 1'b0;
        ret_d       = RET_NONE;

        if (pipe_gnt) begin
            ram_addr    = pipe_addr;
            ram_data    = pipe_wdata;
            ram_byteena = pipe_be;
            ram_wren    = pipe_we;
            if (!pipe_we) begin
                ret_d = RET_PIPE;
            end
        end else if (aux_gnt) begin
            ram_addr    = aux_addr;
            ram_data    = aux_wdata;
            ram_byteena = aux_be;
            ram_wren    = aux_we;
            if (!aux_we) begin
                ret_d = RET_AUX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_q <= RET_NONE;
        end else begin
            ret_q <= ret_d;
        end
    end

    assign pipe_rvalid = (ret_q == RET_PIPE);
    assign aux_rvalid  = (ret_q == RET_AUX);
    assign rdata       = ram_q;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Self-checking bench for dcache_arbiter: behavioural RAM, shadow memory and a
// scoreboard of expected read returns. Honours DCACHE_ARB_STARVE_GUARD_EN.
module tb_dcache_arbiter;

    localparam int unsigned StarveMax = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_req, aux_req, pipe_we, aux_we;
    logic [11:0] pipe_addr, aux_addr;
    logic [31:0] pipe_wdata, aux_wdata;
    logic [3:0]  pipe_be, aux_be;
    logic        pipe_gnt, aux_gnt, pipe_rvalid, aux_rvalid;
    logic [31:0] rdata;
    logic [11:0] ram_addr;
    logic [31:0] ram_data;
    logic [3:0]  ram_byteena;
    logic        ram_wren;
    logic [31:0] ram_q;

    dcache_arbiter #(.STARVE_MAX(StarveMax)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_req   (pipe_req),
        .aux_req    (aux_req),
        .pipe_we    (pipe_we),
        .aux_we     (aux_we),
        .pipe_addr  (pipe_addr),
        .aux_addr   (aux_addr),
        .pipe_wdata (pipe_wdata),
        .aux_wdata  (aux_wdata),
        .pipe_be    (pipe_be),
        .aux_be     (aux_be),
        .pipe_gnt   (pipe_gnt),
        .aux_gnt    (aux_gnt),
        .pipe_rvalid(pipe_rvalid),
        .aux_rvalid (aux_rvalid),
        .rdata      (rdata),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_byteena(ram_byteena),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, read-before-write, 1-cycle latency.
    logic [31:0] mem [4096];
    logic [31:0] shadow [4096];

    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteena[b]) mem[ram_addr][b*8 +: 8] <= ram_data[b*8 +: 8];
            end
        end
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic        is_aux;
        logic [31:0] data;
        int          due;
    } ret_t;

    ret_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   starve_m = 0;
    logic last_pg, last_ag;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic check_returns();
        logic exp_v = 1'b0;
        logic exp_aux = 1'b0;
        if (sb_q.size() > 0) begin
            exp_v   = (sb_q[0].due == cyc);
            exp_aux = sb_q[0].is_aux;
        end
        check_eq("pipe_rvalid", 32'(pipe_rvalid), 32'(exp_v && !exp_aux));
        check_eq("aux_rvalid", 32'(aux_rvalid), 32'(exp_v && exp_aux));
        if (exp_v) begin
            check_eq("rdata", rdata, sb_q[0].data);
            void'(sb_q.pop_front());
        end
    endtask

    // One clock of stimulus; called just after a rising edge, checks at falling edge.
    task automatic step(input logic preq, input logic pwe, input logic [11:0] paddr,
                        input logic [31:0] pwd, input logic [3:0] pbe,
                        input logic areq, input logic awe, input logic [11:0] aaddr,
                        input logic [31:0] awd, input logic [3:0] abe);
        logic force_m, exp_pg, exp_ag;
        pipe_req = preq; pipe_we = pwe; pipe_addr = paddr; pipe_wdata = pwd; pipe_be = pbe;
        aux_req  = areq; aux_we  = awe; aux_addr  = aaddr; aux_wdata  = awd; aux_be  = abe;
        @(negedge clk);
`ifdef DCACHE_ARB_STARVE_GUARD_EN
        force_m = areq && (starve_m == int'(StarveMax));
`else
        force_m = 1'b0;
`endif
        exp_pg = preq && !force_m;
        exp_ag = areq && (!preq || force_m);
        last_pg = pipe_gnt;
        last_ag = aux_gnt;
        check_eq("pipe_gnt", 32'(pipe_gnt), 32'(exp_pg));
        check_eq("aux_gnt", 32'(aux_gnt), 32'(exp_ag));
        check_eq("ram_wren", 32'(ram_wren), 32'(exp_pg ? pwe : (exp_ag ? awe : 1'b0)));
        check_eq("ram_byteena", 32'(ram_byteena), 32'(exp_pg ? pbe : (exp_ag ? abe : 4'h0)));
        check_eq("ram_addr", 32'(ram_addr), 32'(exp_ag ? aaddr : paddr));
        if (exp_pg && pwe) check_eq("ram_data", ram_data, pwd);
        if (exp_ag && awe) check_eq("ram_data", ram_data, awd);
        check_returns();
        if (exp_pg) begin
            if (pwe) shadow[paddr] = merge(shadow[paddr], pwd, pbe);
            else sb_q.push_back('{is_aux: 1'b0, data: shadow[paddr], due: cyc + 1});
        end else if (exp_ag) begin
            if (awe) shadow[aaddr] = merge(shadow[aaddr], awd, abe);
            else sb_q.push_back('{is_aux: 1'b1, data: shadow[aaddr], due: cyc + 1});
        end
        if (areq && !exp_ag) starve_m = (starve_m >= int'(StarveMax)) ? int'(StarveMax)
                                                                      : starve_m + 1;
        else starve_m = 0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    endtask

    // Reset pulse of one clock; any pending read return is lost.
    task automatic pulse_reset();
        pipe_req = 1'b0; aux_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_pipe_rvalid", 32'(pipe_rvalid), 32'h0);
        check_eq("rst_aux_rvalid", 32'(aux_rvalid), 32'h0);
        sb_q.delete();
        starve_m = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_aux;
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
            shadow[i] = mem[i];
        end
        mem[12'h010] = 32'hDEADBEEF; shadow[12'h010] = 32'hDEADBEEF;
        mem[12'h020] = 32'hA5A5A5A5; shadow[12'h020] = 32'hA5A5A5A5;
        rst = 1'b1;
        pipe_req = 0; aux_req = 0; pipe_we = 0; aux_we = 0;
        pipe_addr = 0; aux_addr = 0; pipe_wdata = 0; aux_wdata = 0; pipe_be = 0; aux_be = 0;

        // Reset state
        @(negedge clk);
        check_eq("reset_pipe_rvalid", 32'(pipe_rvalid), 32'h0);
        check_eq("reset_aux_rvalid", 32'(aux_rvalid), 32'h0);
        check_eq("reset_wren", 32'(ram_wren), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Pipe read, aux idle
        step(1, 0, 12'h010, 32'h0, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
        idle();

        // Both request, pipe partial write wins
        step(1, 1, 12'h020, 32'h12345678, 4'b0011, 1, 0, 12'h030, 32'h0, 4'hF);
        idle();

        // Pipe read then aux read (sees merged write)
        step(1, 0, 12'h010, 32'h0, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
        step(0, 0, 12'h0, 32'h0, 4'h0, 1, 0, 12'h020, 32'h0, 4'hF);
        idle();

        // Write then read same address back to back, both requesters
        step(1, 1, 12'h040, 32'hCAFEF00D, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
        step(1, 0, 12'h040, 32'h0, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
        step(0, 0, 12'h0, 32'h0, 4'h0, 1, 1, 12'h041, 32'h87654321, 4'b1100);
        step(0, 0, 12'h0, 32'h0, 4'h0, 1, 0, 12'h041, 32'h0, 4'hF);
        idle();

        // Both held continuously
`ifdef DCACHE_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 12'(i), 32'h0, 4'hF, 1, 0, 12'h100, 32'h0, 4'hF);
            if (i < 4) check_eq("starve_denied", 32'(last_ag), 32'h0);
        end
        check_eq("starve_aux_gnt_c5", 32'(last_ag), 32'h1);
        check_eq("starve_pipe_gnt_c5", 32'(last_pg), 32'h0);
        step(1, 0, 12'h5, 32'h0, 4'hF, 1, 0, 12'h100, 32'h0, 4'hF);
        check_eq("starve_cleared", 32'(last_ag), 32'h0);
        for (int i = 0; i < 10; i++) step(1, 0, 12'(i), 32'h0, 4'hF, 1, 0, 12'h101, 32'h0, 4'hF);
`else
        n_aux = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 12'(i), 32'h0, 4'hF, 1, 0, 12'h100, 32'h0, 4'hF);
            if (last_ag) n_aux++;
        end
        check_eq("strict_aux_never", 32'(n_aux), 32'h0);
`endif
        idle();

        // Reset right after a granted read drops the return
        step(1, 0, 12'h010, 32'h0, 4'hF, 0, 0, 12'h0, 32'h0, 4'h0);
        pulse_reset();
        idle();
        for (int i = 0; i < 6; i++) step(1, 0, 12'(i), 32'h0, 4'hF, 1, 0, 12'h200, 32'h0, 4'hF);
        idle();

        // Randomised traffic over a small address window
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)),
                 $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 12'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        end
        idle();
        check_eq("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
